// File: rtl/cotm32_pkg.sv
// Shared types for the fetch stage: fault codes, FSM states and the
// buffered fetch entry.
package cotm32_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_OK         = 2'd0,
        FETCH_MISALIGNED = 2'd1,
        FETCH_ACCESS     = 2'd2
    } fetch_fault_e;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        fetch_fault_e    fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO holding fetched {pc, instr, fault} entries for decode.
// Flush wins over push/pop in the same cycle.
module fetch_buf
    import cotm32_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) entries[i] <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head  = entries[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction ROM and
// queues classified fetches toward decode; redirects flush and restart.
module instr_fetch
    import cotm32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     IMEM_SIZE = 4096
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [XLEN-1:0] i_imem_rdata,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_instr,
    output fetch_fault_e    o_fault
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    fetch_fault_e    fault;
    fetch_entry_t    din, head;
    logic            push, pop, full, empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= FS_RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        fault   = FETCH_OK;
        if (pc[1:0] != 2'b00)
            fault = FETCH_MISALIGNED;
        else if (pc >= XLEN'(IMEM_SIZE))
            fault = FETCH_ACCESS;

        pop  = !empty && i_ready;
        push = !i_redirect_valid && (state == FS_RUN) && (!full || pop);

        if (i_redirect_valid) begin
            pc_d    = i_redirect_pc;
            state_d = FS_RUN;
        end else if (push) begin
            // A faulting fetch leaves the PC on the faulting address so the
            // ROM address shows where fetch stopped.
            if (fault != FETCH_OK)
                state_d = FS_HALT;
            else
                pc_d = pc + XLEN'(INSTR_BYTES);
        end
    end

    assign din.pc    = pc;
    assign din.instr = (fault == FETCH_OK) ? i_imem_rdata : '0;
    assign din.fault = fault;

    fetch_buf u_buf (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .flush (i_redirect_valid),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_imem_addr = pc;
    assign o_valid     = !empty;
    assign o_pc        = empty ? '0 : head.pc;
    assign o_instr     = empty ? '0 : head.instr;
    assign o_fault     = empty ? FETCH_OK : head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a default-size instance plus a 16-byte ROM
// instance share stimulus; outputs are sampled on the falling edge.
module tb_instr_fetch;
    import cotm32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b0;

    logic [31:0] addr, rdata, pc_o, instr_o;
    logic        valid_o;
    fetch_fault_e fault_o;
    logic [31:0] s_addr, s_rdata, s_pc, s_instr;
    logic        s_valid;
    fetch_fault_e s_fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM word i holds 0x13 + i*0x80
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd4096) return 32'h13 + 32'({a[11:2], 7'b0});
        return 32'h0;
    endfunction

    assign rdata   = rom_word(addr);
    assign s_rdata = rom_word(s_addr);

    instr_fetch dut (
        .i_clk(clk), .i_rst(rst), .o_imem_addr(addr), .i_imem_rdata(rdata),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_valid(valid_o), .i_ready(ready), .o_pc(pc_o), .o_instr(instr_o),
        .o_fault(fault_o)
    );

    instr_fetch #(.IMEM_SIZE(16)) dut_s (
        .i_clk(clk), .i_rst(rst), .o_imem_addr(s_addr), .i_imem_rdata(s_rdata),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
        .o_valid(s_valid), .i_ready(ready), .o_pc(s_pc), .o_instr(s_instr),
        .o_fault(s_fault)
    );

    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        redirect_valid = 1'b0;
        ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({valid_o, addr, pc_o, instr_o, 2'(fault_o)} !== {1'b0, 32'h0, 32'h0, 32'h0, 2'd0}) begin
            n_err++;
            $display("FAIL reset: got v=%0b addr=%h pc=%h instr=%h f=%0d, need v=0 addr=0 pc=0 instr=0 f=0",
                     valid_o, addr, pc_o, instr_o, fault_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_i [4] = '{32'h13, 32'h93, 32'h113, 32'h193};
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({valid_o, pc_o, instr_o, 2'(fault_o)} !== {1'b1, 32'(4*k), exp_i[k], 2'd0}) begin
                n_err++;
                $display("FAIL stream[%0d]: got v=%0b pc=%h instr=%h f=%0d, need v=1 pc=%h instr=%h f=0",
                         k, valid_o, pc_o, instr_o, fault_o, 32'(4*k), exp_i[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_i [4] = '{32'h13, 32'h93, 32'h113, 32'h193};
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        n_vec++;
        if ({valid_o, addr, pc_o, instr_o} !== {1'b1, 32'h8, 32'h0, 32'h13}) begin
            n_err++;
            $display("FAIL backpressure_hold: got v=%0b addr=%h pc=%h instr=%h, need v=1 addr=8 pc=0 instr=13",
                     valid_o, addr, pc_o, instr_o);
        end
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if ({valid_o, pc_o, instr_o} !== {1'b1, 32'(4*k), exp_i[k]}) begin
                n_err++;
                $display("FAIL drain[%0d]: got v=%0b pc=%h instr=%h, need v=1 pc=%h instr=%h",
                         k, valid_o, pc_o, instr_o, 32'(4*k), exp_i[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++;
        if ({valid_o, addr} !== {1'b0, 32'h40}) begin
            n_err++;
            $display("FAIL redirect_flush: got v=%0b addr=%h, need v=0 addr=40", valid_o, addr);
        end
        @(negedge clk);
        n_vec++;
        if ({valid_o, pc_o, instr_o, 2'(fault_o)} !== {1'b1, 32'h40, 32'h813, 2'd0}) begin
            n_err++;
            $display("FAIL redirect_first: got v=%0b pc=%h instr=%h f=%0d, need v=1 pc=40 instr=813 f=0",
                     valid_o, pc_o, instr_o, fault_o);
        end
        @(negedge clk);
        n_vec++;
        if ({valid_o, pc_o, instr_o} !== {1'b1, 32'h44, 32'h893}) begin
            n_err++;
            $display("FAIL redirect_second: got v=%0b pc=%h instr=%h, need v=1 pc=44 instr=893",
                     valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++;
        if ({valid_o, addr} !== {1'b0, 32'h42}) begin
            n_err++;
            $display("FAIL misalign_flush: got v=%0b addr=%h, need v=0 addr=42", valid_o, addr);
        end
        @(negedge clk);
        n_vec++;
        if ({valid_o, pc_o, instr_o, 2'(fault_o)} !== {1'b1, 32'h42, 32'h0, 2'd1}) begin
            n_err++;
            $display("FAIL misalign_entry: got v=%0b pc=%h instr=%h f=%0d, need v=1 pc=42 instr=0 f=1",
                     valid_o, pc_o, instr_o, fault_o);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if ({valid_o, addr} !== {1'b0, 32'h42}) begin
                n_err++;
                $display("FAIL halt[%0d]: got v=%0b addr=%h, need v=0 addr=42", k, valid_o, addr);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({valid_o, pc_o, instr_o, 2'(fault_o)} !== {1'b1, 32'h0, 32'h13, 2'd0}) begin
            n_err++;
            $display("FAIL resume: got v=%0b pc=%h instr=%h f=%0d, need v=1 pc=0 instr=13 f=0",
                     valid_o, pc_o, instr_o, fault_o);
        end
    endtask

    task automatic test_access();
        logic [31:0] exp_i [5] = '{32'h13, 32'h93, 32'h113, 32'h193, 32'h0};
        logic [1:0]  exp_f;
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_f = (k == 4) ? 2'd2 : 2'd0;
            n_vec++;
            if ({s_valid, s_pc, s_instr, 2'(s_fault)} !== {1'b1, 32'(4*k), exp_i[k], exp_f}) begin
                n_err++;
                $display("FAIL access[%0d]: got v=%0b pc=%h instr=%h f=%0d, need v=1 pc=%h instr=%h f=%0d",
                         k, s_valid, s_pc, s_instr, s_fault, 32'(4*k), exp_i[k], exp_f);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({s_valid, s_addr} !== {1'b0, 32'h10}) begin
            n_err++;
            $display("FAIL access_halt: got v=%0b addr=%h, need v=0 addr=10", s_valid, s_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        n_vec++;
        if ({valid_o, addr} !== {1'b1, 32'h8}) begin
            n_err++;
            $display("FAIL pre_async_full: got v=%0b addr=%h, need v=1 addr=8", valid_o, addr);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({valid_o, addr, pc_o} !== {1'b0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b addr=%h pc=%h, need v=0 addr=0 pc=0", valid_o, addr, pc_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_access();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
